twos_to_signmag_serial: RTL and testbench

- Bit-serial converter from two's complement to sign-magnitude. It is the decode direction of the existing combinational 2's-complement negation block.
- Accepts one WIDTH-bit signed word over a valid/ready handshake and processes it LSB-first, one bit per clock.
- Conversion rule: copy bits up to and including the first 1, then invert the remaining bits (negative inputs only).
- Returns sign plus unsigned magnitude over a second valid/ready handshake. Sits between arithmetic datapaths and sign-magnitude consumers (display/BCD stages).

---
 rtl/twos_to_signmag_serial.sv | 134 +++++++++++++
 tb/tb_twos_to_signmag_serial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's complement -> sign-magnitude converter, LSB first, one bit per clock.
// Define MIN_NEG_CLAMP_EN to clamp the most-negative input to 2^(WIDTH-1)-1 and flag it on ovf_o.
module twos_to_signmag_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_sign_o,
  output logic [WIDTH-1:0] out_mag_o,
`ifdef MIN_NEG_CLAMP_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH-1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] out_mag_q, out_mag_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;
  logic             out_sign_q, out_sign_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, last, bit_out, clamp;
  logic [WIDTH-1:0] mag_nxt;

  assign accept  = (state_q == IDLE) && in_valid_i;
  assign last    = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  // Past the first 1 of a negative word every bit is inverted.
  assign bit_out = (sign_q && seen_q) ? ~shift_q[0] : shift_q[0];
  assign mag_nxt = {bit_out, mag_q[WIDTH-1:1]};
`ifdef MIN_NEG_CLAMP_EN
  assign clamp   = sign_q && (mag_nxt == MSB_ONLY);
`else
  assign clamp   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = SHIFT;
      SHIFT:   if (last)        state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == SHIFT) || (state_q == DONE);
  end

  always_comb begin
    shift_d    = shift_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    out_mag_d  = out_mag_q;
    out_sign_d = out_sign_q;
    ovf_d      = ovf_q;
    if (accept) begin
      shift_d = in_data_i;
      sign_d  = in_data_i[WIDTH-1];
      seen_d  = 1'b0;
      cnt_d   = '0;
      mag_d   = '0;
    end else if (state_q == SHIFT) begin
      shift_d = shift_q >> 1;
      seen_d  = seen_q | (sign_q & shift_q[0]);
      cnt_d   = cnt_q + CNT_W'(1);
      mag_d   = mag_nxt;
      if (last) begin
        // Result registers are separate so they hold through IDLE until the next DONE.
        out_mag_d  = clamp ? (MSB_ONLY - WIDTH'(1)) : mag_nxt;
        out_sign_d = sign_q;
        ovf_d      = clamp;
      end
    end else if ((state_q == DONE) && out_ready_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shift_q    <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      seen_q     <= 1'b0;
      cnt_q      <= '0;
      out_mag_q  <= '0;
      out_sign_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      out_mag_q  <= out_mag_d;
      out_sign_q <= out_sign_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_sign_o = out_sign_q;
  assign out_mag_o  = out_mag_q;
`ifdef MIN_NEG_CLAMP_EN
  assign ovf_o      = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ clamp;
`endif

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial (WIDTH=8); inputs driven and outputs sampled on negedge.
module tb_twos_to_signmag_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_sign;
  logic [7:0] out_mag;
  logic       busy;
`ifdef MIN_NEG_CLAMP_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  twos_to_signmag_serial #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sign_o(out_sign),
    .out_mag_o(out_mag),
`ifdef MIN_NEG_CLAMP_EN
    .ovf_o(ovf),
`endif
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: exact accept-to-valid latency, result, then single-cycle consume.
  task automatic run(input string tag, input logic [7:0] d, input logic es,
                     input logic [7:0] em, input logic eovf);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    repeat (7) @(negedge clk);
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sign"}, 32'(out_sign), 32'(es));
    chk({tag, ".mag"}, 32'(out_mag), 32'(em));
`ifdef MIN_NEG_CLAMP_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf) $display("note: %s expects ovf only with clamp enabled", tag);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    chk({tag, ".hold"}, 32'(out_mag), 32'(em));
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_sign", 32'(out_sign), 32'd0);
    chk("rst.out_mag", 32'(out_mag), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Basic conversions
    run("aa", 8'hAA, 1'b1, 8'h56, 1'b0);
    run("05", 8'h05, 1'b0, 8'h05, 1'b0);
    run("00", 8'h00, 1'b0, 8'h00, 1'b0);
    run("ff", 8'hFF, 1'b1, 8'h01, 1'b0);
`ifdef MIN_NEG_CLAMP_EN
    run("80", 8'h80, 1'b1, 8'h7F, 1'b1);
`else
    run("80", 8'h80, 1'b1, 8'h80, 1'b0);
`endif

    // Backpressure: 0x9C = -100 -> mag 0x64; in_valid during DONE must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h9C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("bp.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_sign", 32'(out_sign), 32'd1);
      chk("bp.hold_mag", 32'(out_mag), 32'h64);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.drop", 32'(out_valid), 32'd0);
    chk("bp.rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp.idle_busy", 32'(busy), 32'd0);
    chk("bp.idle_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of SHIFT discards the partial word
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.out_mag", 32'(out_mag), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    run("c8", 8'hC8, 1'b1, 8'h38, 1'b0);

    // Back-to-back with in_valid held and out_ready held; second accept 10 cycles after first
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    out_ready = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) in_data = 8'h7F;
      if (i == 7)  chk("b2b.early1", 32'(out_valid), 32'd0);
      if (i == 8) begin
        chk("b2b.valid1", 32'(out_valid), 32'd1);
        chk("b2b.sign1", 32'(out_sign), 32'd1);
        chk("b2b.mag1", 32'(out_mag), 32'h7F);
      end
      if (i == 9) begin
        chk("b2b.gap_valid", 32'(out_valid), 32'd0);
        chk("b2b.gap_ready", 32'(in_ready), 32'd1);
      end
      if (i == 10) begin
        chk("b2b.accept2", 32'(busy), 32'd1);
        in_valid = 1'b0;
      end
      if (i == 17) chk("b2b.early2", 32'(out_valid), 32'd0);
      if (i == 18) begin
        chk("b2b.valid2", 32'(out_valid), 32'd1);
        chk("b2b.sign2", 32'(out_sign), 32'd0);
        chk("b2b.mag2", 32'(out_mag), 32'h7F);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b.end_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
